// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, total derivations and the axis phase encoding.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} axis_phase_t;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One VGA axis: position counter, ACTIVE/FP/SYNC/BP phase FSM, registered sync/active decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE = DEF_H_ACTIVE,
  parameter int   FP     = DEF_H_FP,
  parameter int   SYNC   = DEF_H_SYNC,
  parameter int   BP     = DEF_H_BP,
  parameter logic POL    = 1'b0
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             adv,
  output logic [CNT_W-1:0] cnt,
  output logic             sync,
  output logic             active,
  output logic             wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] ACT_LAST  = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] FP_LAST   = CNT_W'(ACTIVE + FP - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);

  if (TOTAL > (1 << CNT_W)) begin : g_total_check
    $error("vga_axis_counter: axis total does not fit the counter width");
  end

  axis_phase_t      phase, phase_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  assign wrap    = adv && (cnt == LAST);
  assign cnt_nxt = (cnt == LAST) ? '0 : cnt + CNT_W'(1);

  // Each phase hands over on its own last count.
  always_comb begin
    phase_nxt = phase;
    case (phase)
      PH_ACTIVE: if (cnt == ACT_LAST)  phase_nxt = PH_FP;
      PH_FP:     if (cnt == FP_LAST)   phase_nxt = PH_SYNC;
      PH_SYNC:   if (cnt == SYNC_LAST) phase_nxt = PH_BP;
      PH_BP:     if (cnt == LAST)      phase_nxt = PH_ACTIVE;
      default:                         phase_nxt = PH_BP;
    endcase
  end

  // Decode is taken from the next phase so flags line up with the counter value.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt    <= LAST;
      phase  <= PH_BP;
      sync   <= ~POL;
      active <= 1'b0;
    end else if (adv) begin
      cnt    <= cnt_nxt;
      phase  <= phase_nxt;
      sync   <= (phase_nxt == PH_SYNC) ? POL : ~POL;
      active <= (phase_nxt == PH_ACTIVE);
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing top: chains horizontal wrap into vertical advance, makes strobes.
// Optional frame counter port enabled by VGA_TIMING_FRAME_CNT_EN.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic             frame_start,
  output logic [15:0]      frame_cnt
`else
  output logic             frame_start
`endif
);

  logic h_active, v_active, h_wrap, v_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(SYNC_POL)
  ) u_h (
    .clk_in(clk_in), .reset(reset), .adv(pix_en),
    .cnt(pix_x), .sync(hsync), .active(h_active), .wrap(h_wrap)
  );

  // Vertical axis steps only on the tick that wraps h, so vsync moves with h wrap.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(SYNC_POL)
  ) u_v (
    .clk_in(clk_in), .reset(reset), .adv(h_wrap),
    .cnt(pix_y), .sync(vsync), .active(v_active), .wrap(v_wrap)
  );

  assign video_on = h_active & v_active;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk_in) begin
    if (reset)       frame_cnt <= '0;
    else if (v_wrap) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized bench: default 640x480 instance plus a shrunken-frame instance, both
// checked every cycle against a tick-count position model.
module tb_vga_timing_ctrl;

  localparam int S_HA = 16, S_HF = 4, S_HS = 6, S_HB = 6;
  localparam int S_VA = 6,  S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_FRAME = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);

  typedef struct {
    longint x;
    longint y;
    bit     hs;
    bit     vs;
    bit     von;
  } exp_t;

  logic       clk_in = 1'b0;
  logic       reset, pix_en;
  logic       d_hsync, d_vsync, d_von, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_hsync, s_vsync, s_von, s_ls, s_fs;
  logic [9:0] s_x, s_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] d_fcnt, s_fcnt;
`endif

  int     n_cmp = 0;
  int     n_err = 0;
  longint t = 0;
  bit     tick = 1'b0;

  always #5 clk_in = ~clk_in;

  vga_timing_ctrl dut_d (
    .clk_in(clk_in), .reset(reset), .pix_en(pix_en),
    .hsync(d_hsync), .vsync(d_vsync), .video_on(d_von),
    .pix_x(d_x), .pix_y(d_y), .line_start(d_ls),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_start(d_fs), .frame_cnt(d_fcnt)
`else
    .frame_start(d_fs)
`endif
  );

  vga_timing_ctrl #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .SYNC_POL(1'b0)
  ) dut_s (
    .clk_in(clk_in), .reset(reset), .pix_en(pix_en),
    .hsync(s_hsync), .vsync(s_vsync), .video_on(s_von),
    .pix_x(s_x), .pix_y(s_y), .line_start(s_ls),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_start(s_fs), .frame_cnt(s_fcnt)
`else
    .frame_start(s_fs)
`endif
  );

  task automatic check(input string tag, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (tick count %0d)", tag, act, exp, t);
    end
  endtask

  // Position after t ticks since reset: t=0 is the parked end-of-frame position.
  function automatic exp_t model(input int ha, input int hf, input int hs, input int hb,
                                 input int va, input int vf, input int vs, input int vb,
                                 input longint tk);
    exp_t   e;
    longint ht = ha + hf + hs + hb;
    longint vt = va + vf + vs + vb;
    longint p;
    if (tk == 0) begin
      e.x = ht - 1;
      e.y = vt - 1;
    end else begin
      p   = (tk - 1) % (ht * vt);
      e.x = p % ht;
      e.y = p / ht;
    end
    e.hs  = !(e.x >= ha + hf && e.x < ha + hf + hs);
    e.vs  = !(e.y >= va + vf && e.y < va + vf + vs);
    e.von = (e.x < ha) && (e.y < va);
    return e;
  endfunction

  task automatic cmp_dut(input string p, input exp_t e, input logic [9:0] x, input logic [9:0] y,
                         input logic hs, input logic vs, input logic von,
                         input logic ls, input logic fs);
    check({p, ".pix_x"}, longint'(x), e.x);
    check({p, ".pix_y"}, longint'(y), e.y);
    check({p, ".hsync"}, longint'(hs), longint'(e.hs));
    check({p, ".vsync"}, longint'(vs), longint'(e.vs));
    check({p, ".video_on"}, longint'(von), longint'(e.von));
    check({p, ".line_start"}, longint'(ls), longint'(tick && e.x == 0));
    check({p, ".frame_start"}, longint'(fs), longint'(tick && e.x == 0 && e.y == 0));
  endtask

  task automatic step(input bit en, input bit rst);
    exp_t ed, es;
    pix_en = en;
    reset  = rst;
    @(posedge clk_in);
    if (rst)     t = 0;
    else if (en) t++;
    tick = en && !rst;
    #1;
    ed = model(640, 16, 96, 48, 480, 10, 2, 33, t);
    es = model(S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, t);
    cmp_dut("def", ed, d_x, d_y, d_hsync, d_vsync, d_von, d_ls, d_fs);
    cmp_dut("small", es, s_x, s_y, s_hsync, s_vsync, s_von, s_ls, s_fs);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("def.frame_cnt", longint'(d_fcnt), ((t + 420000 - 1) / 420000) % 65536);
    check("small.frame_cnt", longint'(s_fcnt), ((t + S_FRAME - 1) / S_FRAME) % 65536);
`endif
  endtask

  initial begin
    int hs_cnt, hs_first, von_cnt, ls_cnt, fs_cnt, vs_cnt;
    pix_en = 1'b0;
    reset  = 1'b1;

    // Reset state, then ticks every 4th cycle.
    step(0, 1);
    step(0, 1);
    check("rst.pix_x", longint'(d_x), 799);
    check("rst.pix_y", longint'(d_y), 524);
    check("rst.hsync", longint'(d_hsync), 1);
    for (int i = 0; i < 40; i++) begin
      step(i % 4 == 3, 0);
      if (i == 3) begin
        check("first.x", longint'(d_x), 0);
        check("first.von", longint'(d_von), 1);
        check("first.ls", longint'(d_ls), 1);
        check("first.fs", longint'(d_fs), 1);
      end
      if (i == 4) check("first.fs_drop", longint'(d_fs), 0);
    end

    // One full default line with continuous ticks.
    step(0, 1);
    hs_cnt = 0; hs_first = -1; von_cnt = 0; ls_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      step(1, 0);
      if (!d_hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(d_x);
      end
      if (d_von) von_cnt++;
      if (d_ls)  ls_cnt++;
    end
    check("line.hs_ticks", hs_cnt, 96);
    check("line.hs_first", hs_first, 656);
    check("line.von_ticks", von_cnt, 640);
    check("line.ls_count", ls_cnt, 1);

    // Whole frames on the shrunken instance.
    step(0, 1);
    fs_cnt = 0; vs_cnt = 0; von_cnt = 0;
    for (int i = 0; i < S_FRAME; i++) begin
      step(1, 0);
      if (s_fs)     fs_cnt++;
      if (!s_vsync) vs_cnt++;
      if (s_von)    von_cnt++;
    end
    check("frame.fs_count", fs_cnt, 1);
    check("frame.vs_ticks", vs_cnt, S_VS * (S_HA + S_HF + S_HS + S_HB));
    check("frame.von_ticks", von_cnt, S_HA * S_VA);
    for (int i = 0; i < 2 * S_FRAME; i++) step(1, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("frame.cnt3", longint'(s_fcnt), 3);
`endif

    // Freeze mid-line at x=300.
    step(0, 1);
    for (int i = 0; i < 301; i++) step(1, 0);
    check("hold.pre_x", longint'(d_x), 300);
    ls_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step(0, 0);
      if (d_ls || d_fs) ls_cnt++;
    end
    check("hold.x", longint'(d_x), 300);
    check("hold.strobes", ls_cnt, 0);
    step(1, 0);
    check("hold.next_x", longint'(d_x), 301);

    // Reset together with a tick mid-line.
    step(0, 1);
    for (int i = 0; i < 701; i++) step(1, 0);
    check("midrst.pre_x", longint'(d_x), 700);
    step(1, 1);
    check("midrst.x", longint'(d_x), 799);
    check("midrst.y", longint'(d_y), 524);
    check("midrst.hsync", longint'(d_hsync), 1);
    check("midrst.vsync", longint'(d_vsync), 1);

    // Random ticks with occasional resets.
    step(0, 1);
    for (int i = 0; i < 20000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1999) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
